// File: rtl/gpu_pixel_writer.sv
// Pixel writer: filters the rasterizer pixel stream, buffers survivors in a FIFO
// and drains them to the framebuffer SRAM via req/ack, signalling line completion.
module gpu_pixel_writer #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int ADDR_BITS    = 19,
  parameter int DEPTH        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      px_valid,
  input  logic [WIDTH_BITS-1:0]     px_x,
  input  logic [HEIGHT_BITS-1:0]    px_y,
  input  logic [CHANNEL_BITS-1:0]   px_r,
  input  logic [CHANNEL_BITS-1:0]   px_g,
  input  logic [CHANNEL_BITS-1:0]   px_b,
  output logic                      px_ready,
  input  logic                      line_done,
  output logic                      sram_req,
  output logic [ADDR_BITS-1:0]      sram_addr,
  output logic [3*CHANNEL_BITS-1:0] sram_wdata,
  input  logic                      sram_ack,
  output logic                      flush_done,
  output logic                      idle
);

  localparam int PTR_BITS   = $clog2(DEPTH);
  localparam int CNT_BITS   = PTR_BITS + 1;
  localparam int DATA_BITS  = 3 * CHANNEL_BITS;
  localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

  state_t                  state_r, state_s;
  logic [CNT_BITS-1:0]     count_r, count_nxt_s;
  logic [PTR_BITS-1:0]     rd_ptr_r, wr_ptr_r;
  logic [ENTRY_BITS-1:0]   mem_r [DEPTH];
  logic [WIDTH_BITS-1:0]   last_x_r;
  logic [HEIGHT_BITS-1:0]  last_y_r;
  logic                    last_vld_r;
  logic                    flush_pend_r;

  logic                    xfer_s, offscreen_s, repeat_s, push_s, pop_s;
  logic                    flush_fire_s;
  logic [ADDR_BITS-1:0]    push_addr_s;
  logic [ENTRY_BITS-1:0]   head_s;

  // Acceptance, filtering and FIFO occupancy bookkeeping.
  always_comb begin
    px_ready    = (count_r < CNT_BITS'(DEPTH));
    xfer_s      = px_valid && px_ready;
    offscreen_s = ({1'b0, px_x} >= (WIDTH_BITS+1)'(WIDTH)) ||
                  ({1'b0, px_y} >= (HEIGHT_BITS+1)'(HEIGHT));
    repeat_s    = last_vld_r && (px_x == last_x_r) && (px_y == last_y_r);
    push_s      = xfer_s && !offscreen_s && !repeat_s;
    pop_s       = (state_r == ST_WRITE) && sram_ack;
    push_addr_s = ADDR_BITS'(px_y) * ADDR_BITS'(WIDTH) + ADDR_BITS'(px_x);
    head_s      = mem_r[rd_ptr_r];
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_BITS'(1);
      2'b01:   count_nxt_s = count_r - CNT_BITS'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Write FSM next state and SRAM-side outputs decoded from registered state.
  always_comb begin
    state_s    = state_r;
    sram_req   = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_BITS'(0)) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        sram_req   = 1'b1;
        sram_addr  = head_s[ENTRY_BITS-1:DATA_BITS];
        sram_wdata = head_s[DATA_BITS-1:0];
        if (sram_ack && (count_nxt_s == CNT_BITS'(0))) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WRITE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Flush completion and idle status.
  always_comb begin
    flush_fire_s = flush_pend_r && (count_r == CNT_BITS'(0)) && (state_r == ST_IDLE);
    flush_done   = flush_fire_s;
    idle         = (count_r == CNT_BITS'(0)) && (state_r == ST_IDLE) && !flush_pend_r;
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {push_addr_s, px_r, px_g, px_b};
    end
  end

  // Control state: FSM, pointers, count, repeat filter and flush tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      count_r      <= '0;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      last_x_r     <= '0;
      last_y_r     <= '0;
      last_vld_r   <= 1'b0;
      flush_pend_r <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_BITS'(1);
        last_x_r <= px_x;
        last_y_r <= px_y;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
      end
      // line_done wins over a same-cycle transfer so the next line starts unfiltered
      if (line_done) begin
        last_vld_r <= 1'b0;
      end else if (push_s) begin
        last_vld_r <= 1'b1;
      end
      if (line_done) begin
        flush_pend_r <= 1'b1;
      end else if (flush_fire_s) begin
        flush_pend_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gpu_pixel_writer.md
# gpu_pixel_writer

Downstream stage of the line rasterizer: consumes the per-cycle pixel stream (X, Y, r, g, b), drops off-screen and repeated pixels, and buffers the rest in a small FIFO. Each buffered pixel becomes one framebuffer SRAM write through a req/ack handshake. It also reports when a finished line has fully drained to memory. It sits between the rasterizer and the framebuffer arbiter.

## Interface
Parameters:
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 9, y coordinate width
- CHANNEL_BITS, 8, bits per colour channel
- WIDTH, 640, screen width in pixels
- HEIGHT, 480, screen height in pixels
- ADDR_BITS, 19, framebuffer word-address width
- DEPTH, 8, FIFO entries (power of two)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- px_valid  in  1  pixel present on px_* this cycle
- px_x  in  WIDTH_BITS  pixel x
- px_y  in  HEIGHT_BITS  pixel y
- px_r, px_g, px_b  in  CHANNEL_BITS each  pixel colour
- px_ready  out  1  pixel accepted when px_valid && px_ready
- line_done  in  1  one-cycle pulse: current line complete
- sram_req  out  1  write request
- sram_addr  out  ADDR_BITS  word address = y*WIDTH + x
- sram_wdata  out  3*CHANNEL_BITS  {r, g, b}
- sram_ack  in  1  write accepted this cycle
- flush_done  out  1  one-cycle pulse: line fully written
- idle  out  1  FIFO empty, no request outstanding, no flush pending

## Operation
- Accept: a transfer occurs when px_valid && px_ready. px_ready = (count < DEPTH). It does not depend on px_valid.
- Filter. A transferred pixel is dropped (consumes no FIFO entry) when:
  - px_x >= WIDTH or px_y >= HEIGHT, or
  - last_vld && (px_x, px_y) == (last_x, last_y). This removes the held-endpoint repeats the rasterizer produces.
- Every non-dropped transfer updates last_x/last_y and sets last_vld. line_done clears last_vld. If a transfer and line_done occur in the same cycle, the transfer is filtered first and last_vld then ends cleared.
- Push: the entry stores {addr, r, g, b}, where addr = px_y*WIDTH + px_x. The product is computed at ADDR_BITS width and is at most 307199 at default parameters. No saturation is needed because of the range filter.
- FIFO: circular buffer with rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping naturally, plus count of log2(DEPTH)+1 bits. Simultaneous push and pop leave count unchanged. A push is never attempted when full, because px_ready is low.
- Write FSM:
  - IDLE: sram_req=0. Go to WRITE when count>0.
  - WRITE: sram_req=1, with sram_addr/sram_wdata driven from the head entry, held stable until ack. On sram_ack: pop. Stay in WRITE if count after the pop is >0 (next head presented the following cycle), else go to IDLE.
- Flush: line_done sets flush_pend. When flush_pend && count==0 && state==IDLE, pulse flush_done for one cycle and clear flush_pend. A line_done arriving in that same cycle re-sets flush_pend.
- idle = (count==0) && state==IDLE && !flush_pend.

## Timing
- Reset values: px_ready=1, sram_req=0, sram_addr=0, sram_wdata=0, flush_done=0, idle=1. Also count=0, pointers=0, last_vld=0, flush_pend=0, FSM=IDLE.
- rst asserted mid-operation discards all FIFO contents and any outstanding request. sram_req drops the cycle after rst is sampled.
- Latency, pixel accepted at edge N into an empty FIFO: count=1 after N, FSM in WRITE after N+1, so sram_req is high in cycle N+1→N+2. This gives 2 cycles from acceptance to request.
- With sram_ack tied high, throughput is 1 write per cycle in steady state. The FIFO never fills at 1 pixel/cycle input.
- sram_ack while sram_req=0 is ignored.
- flush_done occurs at the earliest one cycle after the last ack.

## Test plan
- Reset, then a single pixel (x=3, y=2, rgb=0x11/0x22/0x33) with sram_ack high → exactly one request: sram_addr=1283, sram_wdata=0x112233, asserted 2 cycles after acceptance. idle returns to 1.
- Stream of 12 distinct pixels with sram_ack held 0 → px_ready falls after the 8th accept. Release ack → 12 writes in input order, no loss or duplication, px_ready back to 1.
- Same pixel (100, 50) presented 5 consecutive cycles, then line_done, then (100, 50) again → exactly 2 writes, both at address 32100.
- Pixels (640, 0), (0, 480), and the reset-style (640, 480) → all dropped, no sram_req, px_ready stays 1.
- 4 pixels then line_done, with ack asserted every other cycle → flush_done pulses once, exactly one cycle after the 4th ack. A second line_done while idle gives a pulse on the next cycle.
- Assert rst while 5 entries are queued and sram_req is high → next cycle sram_req=0 and idle=1. No further writes occur after rst is released.
